// File: rtl/dmem_byte_bridge_pkg.sv
// Shared constants and helpers for the data-memory byte bridge.
// Holds the legacy enable/zero defines used by the bridge and its testbench,
// plus a byte-lane extraction helper.
package dmem_byte_bridge_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Byte lane k of a 32-bit word (lane 0 = bits 7:0).
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_byte_bridge_if.sv
// Bundle of the MEM-side word request and the 8-bit RAM port of the byte bridge.
// master: MEM stage plus RAM (drives request and ram_din_i, sees result and RAM strobes).
// slave : the bridge itself (consumes request and ram_din_i, drives result and RAM strobes).
interface dmem_byte_bridge_if #(
    parameter int RAM_AW = 17
) ();

    // MEM-side word request
    logic              req_ce_i;
    logic              req_we_i;
    logic [31:0]       req_addr_i;
    logic [3:0]        req_sel_i;
    logic [31:0]       req_wdata_i;

    // MEM-side result
    logic [31:0]       rdata_o;
    logic              busy_o;

    // 8-bit synchronous RAM port
    logic [RAM_AW-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    modport master (
        output req_ce_i, req_we_i, req_addr_i, req_sel_i, req_wdata_i, ram_din_i,
        input  rdata_o, busy_o, ram_addr_o, ram_we_o, ram_dout_o
    );

    modport slave (
        input  req_ce_i, req_we_i, req_addr_i, req_sel_i, req_wdata_i, ram_din_i,
        output rdata_o, busy_o, ram_addr_o, ram_we_o, ram_dout_o
    );

endinterface

// File: rtl/dmem_byte_bridge_lane_pick.sv
// Byte-lane picker: returns the lowest set lane of a 4-bit mask above the current lane.
// Purely combinational, zero latency, no handshake.
// Ports: mask/cur/incl in (incl=1 also accepts cur itself); nxt lane and none-left flag out.
module dmem_lane_pick (
    input  logic [3:0] mask,
    input  logic [1:0] cur,
    input  logic       incl,
    output logic [1:0] nxt,
    output logic       none
);

    // Scan from the top down so the lowest qualifying lane is the one left standing.
    always_comb begin
        nxt  = cur;
        none = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && ((k > int'(cur)) || (incl && (k == int'(cur))))) begin
                nxt  = 2'(k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_byte_bridge.sv
// Data-side MEM bridge: serialises each selected byte lane of a word request onto an 8-bit RAM.
// Latency: load 1+2N cycles (N+2 with DMEM_PIPE_READ_EN), store 1+N, empty mask 1 cycle.
// Backpressure: busy_o (combinational) stalls MEM until the DONE cycle; no RAM-side throttling.
// Ports: clk, rst (async, active-high), bus (slave view of dmem_byte_bridge_if).
// Build option: define DMEM_PIPE_READ_EN to overlap load lanes (address of next lane issued
// while the previous lane's data is captured).
module dmem_byte_bridge
    import dmem_byte_bridge_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic               clk,
    input  logic               rst,
    dmem_byte_bridge_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [RAM_AW-3:0] lat_word;   // word part of the latched byte address
    logic              lat_we;
    logic [3:0]        lat_sel;
    logic [31:0]       lat_wdata;
    logic [1:0]        lane;       // lane whose address is on the RAM port

`ifdef DMEM_PIPE_READ_EN
    logic [1:0]        cap_lane;   // lane whose data arrives this WAIT cycle
    logic              pend;       // lane holds a real address still to be captured
`endif

    logic [1:0]        first_lane;
    logic              first_none;
    logic [1:0]        adv_lane;
    logic              adv_none;
    logic              st_strobe;

    // First lane comes straight from the live request so IDLE can branch in one cycle.
    dmem_lane_pick u_first_pick (
        .mask (bus.req_sel_i),
        .cur  (2'd0),
        .incl (1'b1),
        .nxt  (first_lane),
        .none (first_none)
    );

    // Advancing always works from the latched mask, never the live inputs.
    dmem_lane_pick u_adv_pick (
        .mask (lat_sel),
        .cur  (lane),
        .incl (1'b0),
        .nxt  (adv_lane),
        .none (adv_none)
    );

    // RAM port outputs are pure decodes of registers, so reset clears them at once.
    assign st_strobe      = (state == S_ISSUE) && (lat_we == WriteEnable);
    assign bus.ram_we_o   = st_strobe;
    assign bus.ram_addr_o = {lat_word, lane};
    assign bus.ram_dout_o = st_strobe ? lane_byte(lat_wdata, lane) : 8'h00;

    assign bus.busy_o     = (bus.req_ce_i == ChipEnable) && (state != S_DONE);

    // Address bits outside the RAM window are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr_i[31:RAM_AW], bus.req_addr_i[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state       <= S_IDLE;
            lat_word    <= '0;
            lat_we      <= 1'b0;
            lat_sel     <= 4'b0000;
            lat_wdata   <= ZeroWord;
            lane        <= 2'd0;
            bus.rdata_o <= ZeroWord;
`ifdef DMEM_PIPE_READ_EN
            cap_lane    <= 2'd0;
            pend        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_ce_i == ChipEnable) begin
                        lat_word    <= bus.req_addr_i[RAM_AW-1:2];
                        lat_we      <= bus.req_we_i;
                        lat_sel     <= bus.req_sel_i;
                        lat_wdata   <= bus.req_wdata_i;
                        bus.rdata_o <= ZeroWord;
                        lane        <= first_lane;
                        state       <= first_none ? S_DONE : S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (lat_we == WriteEnable) begin
                        // One strobe per lane; stay in ISSUE while lanes remain.
                        if (adv_none) begin
                            state <= S_DONE;
                        end else begin
                            lane  <= adv_lane;
                        end
                    end else begin
                        state <= S_WAIT;
`ifdef DMEM_PIPE_READ_EN
                        cap_lane <= lane;
                        pend     <= !adv_none;
                        if (!adv_none) begin
                            lane <= adv_lane;
                        end
`endif
                    end
                end

                S_WAIT: begin
`ifdef DMEM_PIPE_READ_EN
                    bus.rdata_o[{cap_lane, 3'b000} +: 8] <= bus.ram_din_i;
                    if (pend) begin
                        // The address just driven becomes next cycle's capture.
                        cap_lane <= lane;
                        pend     <= !adv_none;
                        if (!adv_none) begin
                            lane <= adv_lane;
                        end
                    end else begin
                        state <= S_DONE;
                    end
`else
                    bus.rdata_o[{lane, 3'b000} +: 8] <= bus.ram_din_i;
                    if (adv_none) begin
                        state <= S_DONE;
                    end else begin
                        lane  <= adv_lane;
                        state <= S_ISSUE;
                    end
`endif
                end

                // DONE: MEM samples rdata_o and advances on this edge.
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Self-checking bench for dmem_byte_bridge: byte-wide RAM model plus a word-level
// reference (shadow byte memory and latency formulas), directed and random requests.
module tb_dmem_byte_bridge;
    import dmem_byte_bridge_pkg::*;

    localparam int RAM_AW    = 17;
    localparam int RAM_BYTES = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst;

    dmem_byte_bridge_if #(.RAM_AW(RAM_AW)) bus ();

    dmem_byte_bridge #(.RAM_AW(RAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:RAM_BYTES-1];
    logic [7:0] ref_mem [0:RAM_BYTES-1];
    int         wr_cnt = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    function automatic logic [7:0] init_byte(input int unsigned a);
        case (a)
            32'h104: return 8'h11;
            32'h105: return 8'h22;
            32'h106: return 8'h33;
            32'h107: return 8'h44;
            32'h012: return 8'h80;
            32'h013: return 8'hFF;
            default: return 8'((a * 29) ^ (a >> 7) ^ 32'h5A);
        endcase
    endfunction

    // Synchronous byte RAM, one cycle read latency.
    initial begin : ram_model
        logic             w;
        logic [RAM_AW-1:0] a;
        logic [7:0]       d;
        for (int i = 0; i < RAM_BYTES; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            w = bus.ram_we_o;
            a = bus.ram_addr_o;
            d = bus.ram_dout_o;
            bus.ram_din_i <= ram[a];
            if (w === 1'b1) begin
                ram[a] = d;
                wr_cnt++;
            end
        end
    end

    function automatic logic [31:0] ram_word(input logic [RAM_AW-1:0] base);
        return {ram[base | 17'd3], ram[base | 17'd2], ram[base | 17'd1], ram[base]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [RAM_AW-1:0] base);
        return {ref_mem[base | 17'd3], ref_mem[base | 17'd2], ref_mem[base | 17'd1], ref_mem[base]};
    endfunction

    // One request: model first, then drive, count busy cycles and check the DONE cycle.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wdata, input bit keep_ce, input string tag);
        int                n;
        int                exp_busy;
        int                cyc;
        int                wr0;
        logic [31:0]       exp_rdata;
        logic [RAM_AW-1:0] wbase;
        logic [RAM_AW-1:0] ba;

        n         = $countones(sel);
        wbase     = {addr[RAM_AW-1:2], 2'b00};
        exp_rdata = 32'h0;
        if (n == 0)   exp_busy = 1;
        else if (we)  exp_busy = 1 + n;
        else begin
`ifdef DMEM_PIPE_READ_EN
            exp_busy = n + 2;
`else
            exp_busy = 1 + 2 * n;
`endif
        end
        for (int k = 0; k < 4; k++) begin
            ba = wbase | 17'(k);
            if (sel[k]) begin
                if (we) ref_mem[ba] = wdata[8*k +: 8];
                else    exp_rdata[8*k +: 8] = ref_mem[ba];
            end
        end

        wr0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_ce_i    = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_sel_i   = sel;
        bus.req_wdata_i = wdata;
        @(negedge clk);
        cyc = 0;
        while (bus.busy_o === 1'b1 && cyc < 64) begin
            cyc++;
            @(posedge clk); #1;
            if (cyc == 1) begin
                // Only the latched copy may matter from here on.
                bus.req_we_i    = 1'($urandom_range(0, 1));
                bus.req_addr_i  = $urandom;
                bus.req_sel_i   = 4'($urandom_range(0, 15));
                bus.req_wdata_i = $urandom;
            end
            @(negedge clk);
        end

        chk_cnt++;
        if (cyc !== exp_busy) $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cyc, exp_busy);
        else pass_cnt++;
        chk_cnt++;
        if (bus.rdata_o !== exp_rdata) $display("FAIL %s rdata: got %h expected %h", tag, bus.rdata_o, exp_rdata);
        else pass_cnt++;
        chk_cnt++;
        if ((wr_cnt - wr0) !== (we ? n : 0))
            $display("FAIL %s write_strobes: got %0d expected %0d", tag, wr_cnt - wr0, we ? n : 0);
        else pass_cnt++;
        if (we) begin
            chk_cnt++;
            if (ram_word(wbase) !== ref_word(wbase))
                $display("FAIL %s ram_word@%h: got %h expected %h", tag, wbase, ram_word(wbase), ref_word(wbase));
            else pass_cnt++;
        end
        if (!keep_ce) bus.req_ce_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_ce_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0;
        bus.req_sel_i = '0; bus.req_wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({bus.rdata_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_dout_o, bus.busy_o} !== '0)
            $display("FAIL reset_outputs: rdata=%h we=%b addr=%h dout=%h busy=%b expected all zero",
                     bus.rdata_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_dout_o, bus.busy_o);
        else pass_cnt++;
        bus.req_ce_i = 1'b1; #1;
        chk_cnt++;
        if (bus.busy_o !== 1'b1) $display("FAIL reset_busy_idle: got %b expected 1", bus.busy_o);
        else pass_cnt++;
        bus.req_ce_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        run_req(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1'b0, "load_word");
        chk_cnt++;
        if (bus.rdata_o !== 32'h4433_2211) $display("FAIL load_word_value: got %h expected 44332211", bus.rdata_o);
        else pass_cnt++;
    endtask

    task automatic test_store_byte();
        run_req(1'b1, 32'h0000_0203, 4'b1000, 32'hA5A5_A5A5, 1'b0, "store_byte");
        chk_cnt++;
        if (ram[17'h203] !== 8'hA5) $display("FAIL store_byte_value: got %h expected a5", ram[17'h203]);
        else pass_cnt++;
    endtask

    task automatic test_load_half();
        run_req(1'b0, 32'h0000_0012, 4'b1100, 32'h0, 1'b0, "load_half");
        chk_cnt++;
        if (bus.rdata_o !== 32'hFF80_0000) $display("FAIL load_half_value: got %h expected ff800000", bus.rdata_o);
        else pass_cnt++;
    endtask

    task automatic test_sel_zero();
        run_req(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 1'b0, "sel_zero_load");
        run_req(1'b1, 32'h0000_0300, 4'b0000, 32'hFFFF_FFFF, 1'b0, "sel_zero_store");
    endtask

    task automatic test_reset_mid_store();
        int wr0;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_ce_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 32'h0000_0040;
        bus.req_sel_i = 4'b1111; bus.req_wdata_i = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (bus.ram_we_o !== 1'b1) $display("FAIL rst_mid_third_strobe: got %b expected 1", bus.ram_we_o);
        else pass_cnt++;
        rst = 1'b1; #1;
        chk_cnt++;
        if ({bus.ram_we_o, bus.rdata_o, bus.ram_addr_o, bus.ram_dout_o} !== '0)
            $display("FAIL rst_mid_outputs: we=%b rdata=%h addr=%h dout=%h expected all zero",
                     bus.ram_we_o, bus.rdata_o, bus.ram_addr_o, bus.ram_dout_o);
        else pass_cnt++;
        bus.req_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ref_mem[17'h40] = 8'hEF;
        ref_mem[17'h41] = 8'hBE;
        chk_cnt++;
        if ((wr_cnt - wr0) !== 2) $display("FAIL rst_mid_strobes: got %0d expected 2", wr_cnt - wr0);
        else pass_cnt++;
        chk_cnt++;
        if (ram_word(17'h40) !== ref_word(17'h40))
            $display("FAIL rst_mid_ram_word: got %h expected %h", ram_word(17'h40), ref_word(17'h40));
        else pass_cnt++;
    endtask

    task automatic test_ce_drop();
        int wr0;
        logic [31:0] wd;
        wd  = $urandom;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        bus.req_ce_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 32'h0000_0310;
        bus.req_sel_i = 4'b1111; bus.req_wdata_i = wd;
        @(posedge clk); #1;
        bus.req_ce_i = 1'b0; bus.req_addr_i = $urandom; bus.req_wdata_i = $urandom;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 4; k++) ref_mem[17'h310 | 17'(k)] = wd[8*k +: 8];
        chk_cnt++;
        if ((wr_cnt - wr0) !== 4) $display("FAIL ce_drop_strobes: got %0d expected 4", wr_cnt - wr0);
        else pass_cnt++;
        chk_cnt++;
        if (ram_word(17'h310) !== ref_word(17'h310))
            $display("FAIL ce_drop_ram_word: got %h expected %h", ram_word(17'h310), ref_word(17'h310));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_req(1'b1, 32'h0000_0080, 4'b1111, 32'h1234_5678, 1'b1, "b2b_store");
        run_req(1'b0, 32'h0000_0080, 4'b1111, 32'h0, 1'b0, "b2b_load");
        chk_cnt++;
        if (bus.rdata_o !== 32'h1234_5678) $display("FAIL b2b_value: got %h expected 12345678", bus.rdata_o);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            // Upper address bits are random to exercise wrap-around.
            run_req(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom,
                    bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = init_byte(i);
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half();
        test_sel_zero();
        test_reset_mid_store();
        test_ce_drop();
        test_back_to_back();
        test_random();
        bus.req_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
